contador_secuencia_param: RTL and testbench

//  Parametrised step counter that sequences FSM read/write transactions.
//  - Terminal count is programmable at run time; output runs 0..TC inclusive.
//  - Clock-enable prescaler sets the step rate.
//  - Modes: free-run (wrap) or one-shot; on enable loss the count either clears or pauses.
//  - Feeds step index, tick, wrap and done strobes to the transaction FSM.

---
 rtl/contador_secuencia_param.sv | 141 ++++++++++++++
 tb/tb_contador_secuencia_param.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_secuencia_param.sv
`default_nettype none
// ============================================================================
//  Module   : contador_secuencia_param
//  Purpose  : Programmable-terminal-count step counter with prescaler,
//             free-run/one-shot modes and clear/pause on enable loss.
//  Revision : 1.0 - initial release
// ============================================================================
module contador_secuencia_param #(
    parameter int WIDTH      = 7,
    parameter int TC_DEFAULT = 84,
    parameter int PRESCALE   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             oneshot_i,
    input  logic             hold_i,
    input  logic             start_i,
    input  logic             tc_wr_i,
    input  logic [WIDTH-1:0] tc_in_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tick_o,
    output logic             wrap_o,
    output logic             done_o,
    output logic             busy_o
);

    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] TC_RST = WIDTH'(TC_DEFAULT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tc_q    <= TC_RST;
            pre_q   <= '0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            pre_q   <= pre_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = tc_q;
        pre_d   = pre_q;
        tick_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                pre_d   = '0;
                // TC is only writable here so a run never sees it change
                if (tc_wr_i) begin
                    tc_d = tc_in_i;
                end
                if (en_i && (!oneshot_i || start_i)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (en_i) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d  = '0;
                        tick_d = 1'b1;
                        if (count_q < tc_q) begin
                            count_d = count_q + 1'b1;
                        end else begin
                            count_d = '0;
                            wrap_d  = 1'b1;
                            if (oneshot_i) begin
                                state_d = S_DONE;
                            end
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end else if (hold_i) begin
                    state_d = S_PAUSE;
                end else begin
                    state_d = S_IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end
            end
            S_PAUSE: begin
                if (en_i) begin
                    state_d = S_RUN;
                end else if (!hold_i) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end
            end
            S_DONE: begin
                count_d = '0;
                pre_d   = '0;
                if (en_i && start_i) begin
                    state_d = S_RUN;
                end else if (!en_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
                pre_d   = '0;
            end
        endcase
    end

    assign count_o = count_q;
    assign tick_o  = tick_q;
    assign wrap_o  = wrap_q;
    assign done_o  = (state_q == S_DONE);
    assign busy_o  = (state_q == S_RUN) || (state_q == S_PAUSE);

endmodule
`default_nettype wire

// File: tb/tb_contador_secuencia_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_contador_secuencia_param
//  Purpose  : Checks PRESCALE=1 and PRESCALE=4 counters against a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_contador_secuencia_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, en, oneshot, hold, start, tc_wr;
    logic [6:0] tc_in;
    logic [6:0] cnt_a, cnt_b;
    logic       tick_a, wrap_a, done_a, busy_a;
    logic       tick_b, wrap_b, done_b, busy_b;

    contador_secuencia_param #(.WIDTH(7), .TC_DEFAULT(84), .PRESCALE(1)) dut_a (
        .clk(clk), .reset(reset), .en_i(en), .oneshot_i(oneshot), .hold_i(hold),
        .start_i(start), .tc_wr_i(tc_wr), .tc_in_i(tc_in), .count_o(cnt_a),
        .tick_o(tick_a), .wrap_o(wrap_a), .done_o(done_a), .busy_o(busy_a)
    );

    contador_secuencia_param #(.WIDTH(7), .TC_DEFAULT(84), .PRESCALE(4)) dut_b (
        .clk(clk), .reset(reset), .en_i(en), .oneshot_i(oneshot), .hold_i(hold),
        .start_i(start), .tc_wr_i(tc_wr), .tc_in_i(tc_in), .count_o(cnt_b),
        .tick_o(tick_b), .wrap_o(wrap_b), .done_o(done_b), .busy_o(busy_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: one entry per instance (0: PRESCALE=1, 1: PRESCALE=4)
    int         presc [2] = '{1, 4};
    logic [6:0] m_cnt [2];
    logic [6:0] m_tc  [2];
    int         m_pre [2];
    bit         m_busy[2], m_paused[2], m_done[2], m_tick[2], m_wrap[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = '0; m_tc[i] = 7'd84; m_pre[i] = 0;
            m_busy[i] = 0; m_paused[i] = 0; m_done[i] = 0;
            m_tick[i] = 0; m_wrap[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            m_tick[i] = 0;
            m_wrap[i] = 0;
            if (m_done[i]) begin
                if (!en) m_done[i] = 0;
                else if (start) begin
                    m_done[i] = 0; m_busy[i] = 1; m_cnt[i] = 0; m_pre[i] = 0;
                end
            end else if (!m_busy[i]) begin
                if (tc_wr) m_tc[i] = tc_in;
                if (en && (!oneshot || start)) begin
                    m_busy[i] = 1; m_paused[i] = 0; m_cnt[i] = 0; m_pre[i] = 0;
                end
            end else if (m_paused[i]) begin
                if (en) m_paused[i] = 0;
                else if (!hold) begin
                    m_busy[i] = 0; m_paused[i] = 0; m_cnt[i] = 0; m_pre[i] = 0;
                end
            end else if (!en) begin
                if (hold) m_paused[i] = 1;
                else begin
                    m_busy[i] = 0; m_cnt[i] = 0; m_pre[i] = 0;
                end
            end else begin
                m_pre[i] = m_pre[i] + 1;
                if (m_pre[i] == presc[i]) begin
                    m_pre[i]  = 0;
                    m_tick[i] = 1;
                    if (int'(m_cnt[i]) < int'(m_tc[i])) m_cnt[i] = m_cnt[i] + 7'd1;
                    else begin
                        m_cnt[i]  = 0;
                        m_wrap[i] = 1;
                        if (oneshot) begin
                            m_busy[i] = 0; m_done[i] = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
    endtask

    function automatic logic [10:0] obs(int i);
        if (i == 0) return {cnt_a, tick_a, wrap_a, done_a, busy_a};
        return {cnt_b, tick_b, wrap_b, done_b, busy_b};
    endfunction

    function automatic logic [10:0] expv(int i);
        return {m_cnt[i], m_tick[i], m_wrap[i], m_done[i], m_busy[i]};
    endfunction

    task automatic test_reset();
        reset = 1'b1; en = 0; oneshot = 0; hold = 0; start = 0; tc_wr = 0; tc_in = 0;
        model_reset();
        repeat (2) cycle();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
                failures++;
                $display("FAIL reset dut%0d got=%h exp=%h", i, obs(i), expv(i));
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        en = 1; oneshot = 0;
        repeat (200) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL free_run dut%0d t=%0t got=%h exp=%h", i, $time, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_clear_pause();
        for (int pass = 0; pass < 2; pass++) begin
            int guard = 0;
            en = 1;
            while (m_cnt[0] != 7'd40 && guard < 300) begin
                cycle();
                guard++;
            end
            checks++;
            if (cnt_a !== 7'd40) begin
                failures++;
                $display("FAIL reach40 got=%0d exp=40", cnt_a);
            end
            hold = (pass == 1);
            en = 0;
            repeat (5) begin
                cycle();
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (obs(i) !== expv(i)) begin
                        failures++;
                        $display("FAIL clear_pause%0d dut%0d got=%h exp=%h", pass, i, obs(i), expv(i));
                    end
                end
            end
            en = 1;
            repeat (6) begin
                cycle();
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (obs(i) !== expv(i)) begin
                        failures++;
                        $display("FAIL resume%0d dut%0d got=%h exp=%h", pass, i, obs(i), expv(i));
                    end
                end
            end
            hold = 0;
        end
    endtask

    task automatic test_oneshot();
        en = 0; hold = 0;
        cycle();
        oneshot = 1; en = 1; start = 1;
        for (int n = 0; n < 100; n++) begin
            cycle();
            start = (n == 90);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL oneshot dut%0d n=%0d got=%h exp=%h", i, n, obs(i), expv(i));
                end
            end
        end
        start = 0;
    endtask

    task automatic test_tc_prog();
        en = 0; oneshot = 0; hold = 0;
        cycle();
        for (int n = 0; n < 40; n++) begin
            tc_wr = (n == 0) || (n >= 14 && n < 20) || (n == 27);
            tc_in = (n == 0) ? 7'd3 : (n == 27) ? 7'd0 : 7'd9;
            en    = !(n == 0 || n == 26 || n == 27);
            cycle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL tc_prog dut%0d n=%0d got=%h exp=%h", i, n, obs(i), expv(i));
                end
            end
        end
        tc_wr = 0;
    endtask

    task automatic test_prescale();
        en = 0;
        cycle();
        tc_wr = 1; tc_in = 7'd2;
        cycle();
        tc_wr = 0; en = 1;
        repeat (30) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL prescale dut%0d got=%h exp=%h", i, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        en = 0;
        cycle();
        tc_wr = 1; tc_in = 7'd60;
        cycle();
        tc_wr = 0; en = 1;
        while (m_cnt[0] != 7'd50 && guard < 200) begin
            cycle();
            guard++;
        end
        #2 reset = 1'b1;
        #1 model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs(i) !== expv(i)) begin
                failures++;
                $display("FAIL async_reset dut%0d got=%h exp=%h", i, obs(i), expv(i));
            end
        end
        cycle();
        reset = 1'b0;
        repeat (180) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL post_reset dut%0d got=%h exp=%h", i, obs(i), expv(i));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            en      = ($urandom_range(0, 9) != 0);
            hold    = $urandom_range(0, 1);
            oneshot = ($urandom_range(0, 7) == 0) ? ~oneshot : oneshot;
            start   = ($urandom_range(0, 5) == 0);
            tc_wr   = ($urandom_range(0, 9) == 0);
            tc_in   = 7'($urandom_range(0, 12));
            cycle();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs(i) !== expv(i)) begin
                    failures++;
                    $display("FAIL random dut%0d n=%0d got=%h exp=%h", i, n, obs(i), expv(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_clear_pause();
        test_oneshot();
        test_tc_prog();
        test_prescale();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
